// File: rtl/led_seq_ctrl.sv
// LED sequencer: OFF/ON/BLINK/BURST patterns paced by a CNT_MAX+1 cycle prescaler tick.
// Latency: led updates the cycle after accept. Commands are refused during BURST unless LED_SEQ_ABORT_EN is defined.
module led_seq_ctrl #(
    parameter int CNT_MAX = 1249999,
    parameter int N_LED   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [N_LED-1:0] cmd_mask,
    input  logic [3:0]       cmd_cnt,
    output logic [N_LED-1:0] led,
    output logic             busy,
    output logic             done
);

    localparam logic [23:0] CNT_TOP = 24'(CNT_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEADY,
        S_BLINK,
        S_BURST_ON,
        S_BURST_OFF
    } state_t;

    state_t           state, state_nxt;
    logic [23:0]      pre_cnt;
    logic             tick;
    logic             accept;
    logic [4:0]       pcnt, pcnt_nxt;
    logic [N_LED-1:0] mask_q, mask_nxt;
    logic [N_LED-1:0] led_nxt;
    logic             done_nxt;

    assign busy = (state == S_BURST_ON) || (state == S_BURST_OFF);

`ifdef LED_SEQ_ABORT_EN
    assign cmd_ready = 1'b1;
`else
    assign cmd_ready = !busy;
`endif

    assign accept = cmd_valid && cmd_ready;
    assign tick   = (pre_cnt == CNT_TOP);

    // A new command restarts the phase so its first lit phase is a full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (accept || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 24'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            pcnt   <= '0;
            mask_q <= '0;
            led    <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            pcnt   <= pcnt_nxt;
            mask_q <= mask_nxt;
            led    <= led_nxt;
            done   <= done_nxt;
        end
    end

    // Accept has priority over a coincident tick.
    always_comb begin
        state_nxt = state;
        pcnt_nxt  = pcnt;
        mask_nxt  = mask_q;
        led_nxt   = led;
        done_nxt  = 1'b0;
        if (accept) begin
            mask_nxt = cmd_mask;
            case (cmd_mode)
                2'd0: begin
                    led_nxt   = '0;
                    state_nxt = S_IDLE;
                end
                2'd1: begin
                    led_nxt   = cmd_mask;
                    state_nxt = S_STEADY;
                end
                2'd2: begin
                    led_nxt   = cmd_mask;
                    state_nxt = S_BLINK;
                end
                default: begin
                    led_nxt   = cmd_mask;
                    pcnt_nxt  = (cmd_cnt == 4'd0) ? 5'd16 : {1'b0, cmd_cnt};
                    state_nxt = S_BURST_ON;
                end
            endcase
        end else if (tick) begin
            case (state)
                S_BLINK: begin
                    led_nxt = led ^ mask_q;
                end
                S_BURST_ON: begin
                    led_nxt   = '0;
                    pcnt_nxt  = pcnt - 5'd1;
                    state_nxt = S_BURST_OFF;
                end
                S_BURST_OFF: begin
                    if (pcnt == 5'd0) begin
                        led_nxt   = '0;
                        done_nxt  = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        led_nxt   = mask_q;
                        state_nxt = S_BURST_ON;
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with CNT_MAX=3 (4-cycle phases), N_LED=4.
module tb_led_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [3:0] cmd_mask;
    logic [3:0] cmd_cnt;
    logic [3:0] led;
    logic       busy;
    logic       done;

    int total;
    int bad;

    led_seq_ctrl #(.CNT_MAX(3), .N_LED(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_mask  (cmd_mask),
        .cmd_cnt   (cmd_cnt),
        .led       (led),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a command for one edge; returns in the cycle after that edge.
    task automatic issue(input logic [1:0] mode, input logic [3:0] mask, input logic [3:0] cnt);
        cmd_mode  = mode;
        cmd_mask  = mask;
        cmd_cnt   = cnt;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    logic       exp_rdy_burst;
    logic [3:0] exp_led;
    int         n;
    logic       seen_done;

    initial begin
        total = 0;
        bad = 0;
`ifdef LED_SEQ_ABORT_EN
        exp_rdy_burst = 1'b1;
`else
        exp_rdy_burst = 1'b0;
`endif
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_mode = 2'd0;
        cmd_mask = 4'd0;
        cmd_cnt = 4'd0;
        repeat (3) step();
        chk("rst_state", {26'd0, led, busy, done}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        rst_n = 1'b1;
        step();

        // ON holds its mask
        issue(2'd1, 4'b0101, 4'd0);
        chk("on_first", {26'd0, led, busy, done}, {26'd0, 4'b0101, 2'b00});
        for (int i = 0; i < 20; i++) begin
            step();
            chk("on_hold", {26'd0, led, busy, done}, {26'd0, 4'b0101, 2'b00});
        end

        // BLINK: 4 lit, 4 dark, repeating
        issue(2'd2, 4'b0011, 4'd0);
        for (int i = 0; i < 16; i++) begin
            exp_led = ((i / 4) % 2 == 0) ? 4'b0011 : 4'b0000;
            chk("blink", {28'd0, led}, {28'd0, exp_led});
            step();
        end
        issue(2'd0, 4'b1111, 4'd0);
        chk("off_after_blink", {28'd0, led}, 32'd0);

        // BLINK restarted mid-phase: new mask gets a full lit phase
        issue(2'd2, 4'b0011, 4'd0);
        step();
        issue(2'd2, 4'b0110, 4'd0);
        for (int i = 0; i < 8; i++) begin
            exp_led = (i < 4) ? 4'b0110 : 4'b0000;
            chk("blink_restart", {28'd0, led}, {28'd0, exp_led});
            step();
        end

        // Accept on a tick edge: tick must not toggle the new value
        issue(2'd2, 4'b0011, 4'd0);
        step(); step(); step();
        issue(2'd1, 4'b1100, 4'd0);
        for (int i = 0; i < 6; i++) begin
            chk("accept_on_tick", {28'd0, led}, {28'd0, 4'b1100});
            step();
        end
        issue(2'd0, 4'b0000, 4'd0);

        // BURST of 2 pulses
        issue(2'd3, 4'b1000, 4'd2);
        for (int i = 0; i < 16; i++) begin
            exp_led = ((i / 4) % 2 == 0) ? 4'b1000 : 4'b0000;
            chk("burst2", {25'd0, led, busy, done, cmd_ready},
                {25'd0, exp_led, 1'b1, 1'b0, exp_rdy_burst});
            step();
        end
        chk("burst2_done", {25'd0, led, busy, done, cmd_ready}, {25'd0, 4'b0000, 3'b011});
        step();
        chk("burst2_idle", {26'd0, led, busy, done}, 32'd0);

        // BURST with cnt=0 means 16 pulses
        issue(2'd3, 4'b0001, 4'd0);
        n = 0;
        while (!done && n < 300) begin
            step();
            n++;
        end
        chk("burst16_len", n, 128);

        // Command held during a 1-pulse burst
        step();
        issue(2'd3, 4'b0100, 4'd1);
        chk("hold_ready", {31'd0, cmd_ready}, {31'd0, exp_rdy_burst});
        cmd_mode = 2'd1;
        cmd_mask = 4'b0010;
        cmd_valid = 1'b1;
        n = 0;
        seen_done = 1'b0;
        while (led != 4'b0010 && n < 40) begin
            step();
            n++;
            if (done) seen_done = 1'b1;
        end
        cmd_valid = 1'b0;
`ifdef LED_SEQ_ABORT_EN
        chk("held_accept_cyc", n, 1);
        chk("held_done", {31'd0, seen_done}, 32'd0);
`else
        chk("held_accept_cyc", n, 9);
        chk("held_done", {31'd0, seen_done}, 32'd1);
`endif
        step();
        chk("held_steady", {26'd0, led, busy, done}, {26'd0, 4'b0010, 2'b00});

        // Reset in the middle of a burst
        issue(2'd3, 4'b1111, 4'd3);
        repeat (5) step();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_async", {26'd0, led, busy, done}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done) seen_done = 1'b1;
        end
        chk("midrst_after", {25'd0, led, busy, done, cmd_ready}, 32'd1);
        chk("midrst_nodone", {31'd0, seen_done}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter CNT_MAX, default 1249999: tick period is CNT_MAX+1 clk cycles.
REQ-002 Parameter N_LED, default 4: number of LED outputs.
REQ-003 Port clk, input, 1: single clock, all logic on rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port cmd_valid, input, 1: command offered.
REQ-006 Port cmd_ready, output, 1: command can be accepted this cycle.
REQ-007 Port cmd_mode, input, 2: 0 OFF, 1 ON, 2 BLINK, 3 BURST.
REQ-008 Port cmd_mask, input, N_LED: LEDs driven by the command.
REQ-009 Port cmd_cnt, input, 4: BURST pulse count; 0 means 16.
REQ-010 Port led, output, N_LED: LED drive, 1 = lit.
REQ-011 Port busy, output, 1: high while in BURST.
REQ-012 Port done, output, 1: one-cycle pulse at BURST completion.

Function
REQ-013 Prescaler: 24-bit counter counting 0..CNT_MAX then wrapping to 0; tick = 1 for the single cycle where counter == CNT_MAX.
REQ-014 Accept = cmd_valid && cmd_ready; on accept: latch mode, mask and cnt, clear prescaler to 0; new led value visible the cycle after accept.
REQ-015 States: IDLE, STEADY, BLINK, BURST_ON, BURST_OFF.
REQ-016 OFF accepted: led <= 0, next state IDLE.
REQ-017 ON accepted: led <= mask, next state STEADY; led holds until the next accept.
REQ-018 BLINK accepted: led <= mask, next state BLINK; each tick led <= led ^ mask; runs until the next accept.
REQ-019 BURST accepted: led <= mask, pulse counter <= cmd_cnt (0 -> 16), next state BURST_ON.
REQ-020 BURST_ON on tick: led <= 0, decrement pulse counter, go BURST_OFF.
REQ-021 BURST_OFF on tick: if pulse counter == 0, done = 1 for one cycle and go IDLE with led = 0; otherwise led <= mask and go BURST_ON.
REQ-022 Each lit and dark phase lasts exactly CNT_MAX+1 cycles, so a BURST of n pulses takes 2n(CNT_MAX+1) cycles from accept to done.
REQ-023 cmd_ready = 1 in IDLE, STEADY and BLINK; value in BURST_ON and BURST_OFF per REQ-029.
REQ-024 busy = 1 exactly in BURST_ON and BURST_OFF.
REQ-025 Accept coinciding with a tick: the accept wins, the prescaler clears, and the tick has no effect on led or state.
REQ-026 Only LEDs in mask toggle; LEDs outside mask are 0 after any accept.

Reset
REQ-027 rst_n low (asynchronous): state IDLE, prescaler 0, pulse counter 0, led 0, done 0, busy 0, latched mask 0.
REQ-028 Reset asserted mid-BURST abandons the burst immediately with no done pulse; after release the block is in IDLE with cmd_ready = 1.

Configuration
REQ-029 Macro LED_SEQ_ABORT_EN defined: cmd_ready = 1 in every state; an accept during BURST abandons it without a done pulse and starts the new command per REQ-014. Macro undefined: cmd_ready = 0 in BURST_ON and BURST_OFF, so a burst always completes.

Verification (CNT_MAX=3, N_LED=4)
REQ-030 Reset, then ON with mask 4'b0101 -> led = 0101 the cycle after accept; held 20 cycles; busy = 0, done = 0.
REQ-031 BLINK with mask 4'b0011 -> led = 0011 for 4 cycles, 0000 for 4 cycles, repeating; a following OFF gives led = 0000 the cycle after accept.
REQ-032 BURST with cnt = 2, mask 4'b1000 -> led = 1000,0,1000,0 in 4-cycle phases; done pulses 16 cycles after accept; busy high for those 16 cycles; then IDLE.
REQ-033 BURST with cnt = 0 -> 16 pulses; done 128 cycles after accept.
REQ-034 BURST in progress with a new cmd_valid held -> without the macro, cmd_ready = 0 until IDLE and the new command is accepted after done; with LED_SEQ_ABORT_EN, accepted at once with no done pulse.
REQ-035 rst_n pulsed low mid-BURST -> led = 0, busy = 0 immediately, no done pulse; cmd_ready = 1 after release.
